// File: rtl/fpu_lifecycle_if.sv
// fpu_lifecycle_if: lifecycle bus between the process manager (master) and one FPU agent (slave).
interface fpu_lifecycle_if #(
    parameter int FPU_ID_WIDTH = 4,
    parameter int MAX_FORK     = 4
);
    logic [FPU_ID_WIDTH-1:0]          init_fpu_id;
    logic [3:0]                       init_process_type;
    logic [31:0]                      init_process_data;
    logic                             init_valid;
    logic                             init_ready;
    logic [FPU_ID_WIDTH-1:0]          schedule_fpu_id;
    logic                             schedule_valid;
    logic                             schedule_ready;
    logic [FPU_ID_WIDTH-1:0]          fork_request_from;
    logic [3:0]                       fork_request_count;
    logic                             fork_request_valid;
    logic                             fork_grant;
    logic [MAX_FORK*FPU_ID_WIDTH-1:0] new_process_ids;
    logic [FPU_ID_WIDTH-1:0]          terminate_process_id;
    logic                             terminate_valid;

    modport master (
        output init_fpu_id, init_process_type, init_process_data, init_valid,
        output schedule_fpu_id, schedule_valid, fork_grant, new_process_ids,
        input  init_ready, schedule_ready, fork_request_from, fork_request_count,
        input  fork_request_valid, terminate_process_id, terminate_valid
    );

    modport slave (
        input  init_fpu_id, init_process_type, init_process_data, init_valid,
        input  schedule_fpu_id, schedule_valid, fork_grant, new_process_ids,
        output init_ready, schedule_ready, fork_request_from, fork_request_count,
        output fork_request_valid, terminate_process_id, terminate_valid
    );
endinterface

// File: rtl/fpu_lifecycle_agent.sv
// fpu_lifecycle_agent: per-FPU lifecycle endpoint (init, schedule, fork, terminate, run gating).
// Optional LIFECYCLE_STATS_EN adds saturating fork/run statistics counters.
module fpu_lifecycle_agent #(
    parameter int FPU_ID_WIDTH = 4,
    parameter int MAX_FORK     = 4,
    parameter int FORK_TIMEOUT = 64
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [FPU_ID_WIDTH-1:0]          my_id,
    fpu_lifecycle_if.slave                   bus,
    output logic                             core_run,
    output logic [3:0]                       core_proc_type,
    output logic [31:0]                      core_proc_data,
    input  logic                             core_fork_req,
    input  logic [3:0]                       core_fork_count,
    input  logic                             core_terminate,
    output logic                             core_fork_done,
    output logic                             core_fork_fail,
    output logic [MAX_FORK*FPU_ID_WIDTH-1:0] core_child_ids
`ifdef LIFECYCLE_STATS_EN
    ,
    output logic [15:0]                      stat_forks_ok,
    output logic [15:0]                      stat_forks_fail,
    output logic [15:0]                      stat_runs
`endif
);
    typedef enum logic [2:0] {IDLE, LOADED, RUNNING, FORK_WAIT, TERM} state_t;

    state_t                           state_q, state_d;
    logic [3:0]                       type_q, type_d, fcnt_q, fcnt_d;
    logic [31:0]                      data_q, data_d;
    logic [MAX_FORK*FPU_ID_WIDTH-1:0] child_q, child_d;
    logic [15:0]                      timer_q, timer_d;
    logic                             pend_q, pend_d, done_q, done_d, fail_q, fail_d;
    logic                             run_q, fvalid_q, tvalid_q;
    logic [FPU_ID_WIDTH-1:0]          tid_q;
    logic                             init_hit, sched_hit;

    assign init_hit  = bus.init_valid && bus.init_fpu_id == my_id;
    assign sched_hit = bus.schedule_valid && bus.schedule_fpu_id == my_id;

    always_comb begin
        state_d = state_q;
        type_d  = type_q;
        data_d  = data_q;
        fcnt_d  = fcnt_q;
        child_d = child_q;
        timer_d = timer_q;
        pend_d  = pend_q;
        done_d  = 1'b0;
        fail_d  = 1'b0;
        case (state_q)
            IDLE: if (init_hit) begin
                state_d = LOADED;
                type_d  = bus.init_process_type;
                data_d  = bus.init_process_data;
            end
            LOADED: if (sched_hit) state_d = RUNNING;
            RUNNING: if (core_terminate || pend_q) begin
                state_d = TERM;
                pend_d  = 1'b0;
            end else if (core_fork_req) begin
                if (core_fork_count == 4'd0 || int'(core_fork_count) > MAX_FORK) fail_d = 1'b1;
                else begin
                    state_d = FORK_WAIT;
                    fcnt_d  = core_fork_count;
                    timer_d = 16'd0;
                end
            end
            FORK_WAIT: begin
                if (core_terminate) pend_d = 1'b1;
                // grant is checked first so it wins over a same-cycle timeout
                if (bus.fork_grant) begin
                    state_d = RUNNING;
                    done_d  = 1'b1;
                    for (int k = 0; k < MAX_FORK; k++)
                        child_d[k*FPU_ID_WIDTH +: FPU_ID_WIDTH] = (k < int'(fcnt_q)) ?
                            bus.new_process_ids[k*FPU_ID_WIDTH +: FPU_ID_WIDTH] : '1;
                end else if (FORK_TIMEOUT != 0 && timer_q + 16'd1 == 16'(FORK_TIMEOUT)) begin
                    state_d = RUNNING;
                    fail_d  = 1'b1;
                end else timer_d = timer_q + 16'd1;
            end
            TERM: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            type_q   <= '0;
            data_q   <= '0;
            fcnt_q   <= '0;
            child_q  <= '1;
            timer_q  <= '0;
            pend_q   <= 1'b0;
            done_q   <= 1'b0;
            fail_q   <= 1'b0;
            run_q    <= 1'b0;
            fvalid_q <= 1'b0;
            tvalid_q <= 1'b0;
            tid_q    <= '0;
        end else begin
            state_q  <= state_d;
            type_q   <= type_d;
            data_q   <= data_d;
            fcnt_q   <= fcnt_d;
            child_q  <= child_d;
            timer_q  <= timer_d;
            pend_q   <= pend_d;
            done_q   <= done_d;
            fail_q   <= fail_d;
            run_q    <= state_d == RUNNING && !pend_d;
            fvalid_q <= state_d == FORK_WAIT;
            tvalid_q <= state_d == TERM;
            tid_q    <= state_d == TERM ? my_id : '0;
        end
    end

    assign bus.init_ready           = state_q == IDLE;
    assign bus.schedule_ready       = state_q == LOADED || state_q == RUNNING;
    assign bus.fork_request_from    = my_id;
    assign bus.fork_request_count   = fcnt_q;
    assign bus.fork_request_valid   = fvalid_q;
    assign bus.terminate_process_id = tid_q;
    assign bus.terminate_valid      = tvalid_q;
    assign core_run                 = run_q;
    assign core_proc_type           = type_q;
    assign core_proc_data           = data_q;
    assign core_fork_done           = done_q;
    assign core_fork_fail           = fail_q;
    assign core_child_ids           = child_q;

`ifdef LIFECYCLE_STATS_EN
    logic [15:0] ok_q, ok_d, bad_q, bad_d, runs_q, runs_d;

    always_comb begin
        ok_d   = ok_q + 16'(done_d && ok_q != 16'hFFFF);
        bad_d  = bad_q + 16'(fail_d && bad_q != 16'hFFFF);
        runs_d = runs_q + 16'(state_q == LOADED && state_d == RUNNING && runs_q != 16'hFFFF);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ok_q   <= '0;
            bad_q  <= '0;
            runs_q <= '0;
        end else begin
            ok_q   <= ok_d;
            bad_q  <= bad_d;
            runs_q <= runs_d;
        end
    end

    assign stat_forks_ok   = ok_q;
    assign stat_forks_fail = bad_q;
    assign stat_runs       = runs_q;
`endif
endmodule
